traffic_safety_monitor: RTL
===========================

Name: traffic_safety_monitor

Overview:
Independent observer of the traffic light controller's lamp outputs. Checks lamp legality, cross-group conflicts, minimum green, yellow length and all-red clearance. Latches the first fault and raises a flash-red request back to the controller. Sits beside the controller at intersection top level; drives nothing except its fault outputs.

Parameters:
MIN_GREEN, 20, minimum cycles a through green (ns_green/ew_green) must stay asserted
YELLOW_CYC, 5, exact cycles a yellow must stay asserted
ALLRED_CYC, 2, minimum cycles both groups must be stopped before either group goes
CNT_W, 8, width of internal duration counters (saturating)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
clr_fault  in  1  synchronous request to clear the latched fault
ns_green, ns_yellow, ns_red  in  1 each  NS through lamps
ew_green, ew_yellow, ew_red  in  1 each  EW through lamps
n_left_green, s_left_green, e_left_green, w_left_green  in  1 each  left-turn green lamps
n_left_red, s_left_red, e_left_red, w_left_red  in  1 each  left-turn red lamps
fault  out  1  sticky fault flag
fault_code  out  3  code of the latched fault (0 = none)
flash_req  out  1  request for the controller to enter flash-red; equals fault
viol_cnt  out  8  count of cycles with any active violation, saturating at 255

Behaviour:
- Reset (async, rst_n=0): fault=0, fault_code=0, flash_req=0, viol_cnt=0. Counters cleared. Both group trackers enter UNKNOWN.
- All inputs are sampled on each rising edge. A violation in the values sampled at edge k is registered at edge k, so fault is visible in the cycle after the offending input.
- Group definitions: NS_go = ns_green|ns_yellow|n_left_green|s_left_green. EW_go is defined likewise. A group is stopped when its _go=0.
- Per-group tracker FSM, states UNKNOWN, RED, GREEN, YELLOW:
  - The state follows the through lamp.
  - UNKNOWN leaves on the first legal lamp value. The interval entered from UNKNOWN is not length-checked.
  - On each transition, the duration counter restarts at 1. The counter saturates at 2^CNT_W-1.
- Violation codes. When several fire in one cycle, the lowest code wins:
  - 1 ILLEGAL_LAMP: a through group does not have exactly one of green/yellow/red asserted; or any left lamp pair has green==red.
  - 2 CONFLICT: NS_go and EW_go are both 1.
  - 3 SHORT_GREEN: GREEN→YELLOW with green counter < MIN_GREEN.
  - 4 BAD_YELLOW: YELLOW→RED with yellow counter != YELLOW_CYC; or a direct GREEN→RED transition.
  - 5 NO_CLEARANCE: a group goes 0→1 while the all-red counter < ALLRED_CYC. The all-red counter increments while both groups are stopped and resets to 0 otherwise.
  - Codes 3 and 4 are suppressed for an interval entered from UNKNOWN.
- Latching:
  - On the first violation while fault=0: fault=1 and fault_code=that code.
  - Later violations do not change fault_code.
- Clearing:
  - clr_fault=1 at an edge with no violation in that cycle clears fault and fault_code.
  - clr_fault=1 together with a violation: the fault stays set and fault_code is reloaded with the new code.
- viol_cnt increments on every cycle with a violation, saturating at 255. It is not cleared by clr_fault.
- Trackers keep running while fault=1; the monitor never stops observing.
- Reset mid-interval: everything returns to reset values and trackers go to UNKNOWN, so the next interval is unchecked.

Test Plan:
- Legal cycle: NS green 20 cycles → yellow 5 → both red 2 → EW green 20 → yellow 5 → both red 2, repeated 3 times → fault=0, viol_cnt=0.
- Short green: after one legal cycle, NS green held 12 cycles then yellow → fault=1 and fault_code=3 on the cycle after yellow is sampled; flash_req=1.
- Conflict plus illegal lamp in the same cycle: ns_green=1, e_left_green=1 with e_left_red=1 → fault_code=1 (priority); viol_cnt increments by 1 per offending cycle.
- Yellow/clearance:
  - Yellow held 6 cycles → code 4.
  - After clr_fault: EW green 1 cycle after NS red → code 5.
  - Direct green→red → code 4.
- Clear behaviour: clr_fault pulsed during a clean cycle → fault=0, fault_code=0, viol_cnt unchanged. clr_fault held during a conflict cycle → fault stays 1 and fault_code=2.
- Async reset mid-green: rst_n low for 3 ns between edges → outputs go to 0 immediately. After release, the first green ends after 5 cycles with no fault (UNKNOWN suppression). The following green ends after 5 cycles → code 3.

Source files
------------

// File: rtl/traffic_safety_monitor.sv
// Independent lamp-output observer for the intersection controller.
// Flags illegal lamp combinations, cross-group conflicts, short greens,
// wrong yellow lengths and missing all-red clearance, latches the first
// fault and requests flash-red.
module traffic_safety_monitor #(
    parameter int unsigned MIN_GREEN  = 20,
    parameter int unsigned YELLOW_CYC = 5,
    parameter int unsigned ALLRED_CYC = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_fault,
    input  logic       ns_green,
    input  logic       ns_yellow,
    input  logic       ns_red,
    input  logic       ew_green,
    input  logic       ew_yellow,
    input  logic       ew_red,
    input  logic       n_left_green,
    input  logic       s_left_green,
    input  logic       e_left_green,
    input  logic       w_left_green,
    input  logic       n_left_red,
    input  logic       s_left_red,
    input  logic       e_left_red,
    input  logic       w_left_red,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash_req,
    output logic [7:0] viol_cnt
);

    localparam int unsigned       NGRP        = 2;
    localparam int unsigned       VC_W        = 8;
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
    localparam logic [CNT_W-1:0]  MIN_GREEN_C = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0]  YELLOW_C    = CNT_W'(YELLOW_CYC);
    localparam logic [CNT_W-1:0]  ALLRED_C    = CNT_W'(ALLRED_CYC);
    localparam logic [VC_W-1:0]   VC_MAX      = '1;

    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_ILLEGAL  = 3'd1;
    localparam logic [2:0] CODE_CONFLICT = 3'd2;
    localparam logic [2:0] CODE_SHORT    = 3'd3;
    localparam logic [2:0] CODE_YELLOW   = 3'd4;
    localparam logic [2:0] CODE_CLEAR    = 3'd5;

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'd0,
        ST_RED     = 2'd1,
        ST_GREEN   = 2'd2,
        ST_YELLOW  = 2'd3
    } trk_state_e;

    // Per-group tracker state (index 0 = NS, 1 = EW)
    trk_state_e       st_q       [NGRP];
    logic [CNT_W-1:0] dur_q      [NGRP];
    logic [NGRP-1:0]  from_unk_q;
    logic [NGRP-1:0]  go_q;
    logic [CNT_W-1:0] allred_q;

    // Combinational decode of the current sample
    trk_state_e      lamp_st [NGRP];
    logic [NGRP-1:0] grn, ylw, red;
    logic [NGRP-1:0] go, lamp_ok, trans, short_g, bad_y, no_clr;
    logic            left_bad, illegal, conflict;
    logic [2:0]      viol_code;

    // Lamp legality, transition detection and violation priority encode
    always_comb begin
        grn      = {ew_green,  ns_green};
        ylw      = {ew_yellow, ns_yellow};
        red      = {ew_red,    ns_red};
        go[0]    = ns_green | ns_yellow | n_left_green | s_left_green;
        go[1]    = ew_green | ew_yellow | e_left_green | w_left_green;
        left_bad = (n_left_green == n_left_red) | (s_left_green == s_left_red) |
                   (e_left_green == e_left_red) | (w_left_green == w_left_red);
        lamp_ok  = '0;
        trans    = '0;
        short_g  = '0;
        bad_y    = '0;
        no_clr   = '0;
        for (int i = 0; i < NGRP; i++) begin
            lamp_st[i] = ST_RED;
            if (grn[i])      lamp_st[i] = ST_GREEN;
            else if (ylw[i]) lamp_st[i] = ST_YELLOW;
            lamp_ok[i] = ($countones({grn[i], ylw[i], red[i]}) == 1);
            trans[i]   = lamp_ok[i] && (lamp_st[i] != st_q[i]);
            short_g[i] = trans[i] && !from_unk_q[i] && (st_q[i] == ST_GREEN) &&
                         (lamp_st[i] == ST_YELLOW) && (dur_q[i] < MIN_GREEN_C);
            bad_y[i]   = trans[i] && !from_unk_q[i] && (lamp_st[i] == ST_RED) &&
                         (((st_q[i] == ST_YELLOW) && (dur_q[i] != YELLOW_C)) ||
                          (st_q[i] == ST_GREEN));
            no_clr[i]  = (st_q[i] != ST_UNKNOWN) && go[i] && !go_q[i] &&
                         (allred_q < ALLRED_C);
        end
        illegal  = left_bad | ~(&lamp_ok);
        conflict = &go;
        if (illegal)       viol_code = CODE_ILLEGAL;
        else if (conflict) viol_code = CODE_CONFLICT;
        else if (|short_g) viol_code = CODE_SHORT;
        else if (|bad_y)   viol_code = CODE_YELLOW;
        else if (|no_clr)  viol_code = CODE_CLEAR;
        else               viol_code = CODE_NONE;
    end

    // Trackers, duration counters, fault latch and violation counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NGRP; i++) begin
                st_q[i]  <= ST_UNKNOWN;
                dur_q[i] <= '0;
            end
            from_unk_q <= '0;
            go_q       <= '0;
            allred_q   <= '0;
            fault      <= 1'b0;
            fault_code <= CODE_NONE;
            viol_cnt   <= '0;
        end else begin
            for (int i = 0; i < NGRP; i++) begin
                if (trans[i]) begin
                    st_q[i]       <= lamp_st[i];
                    dur_q[i]      <= CNT_ONE;
                    from_unk_q[i] <= (st_q[i] == ST_UNKNOWN);
                end else if (dur_q[i] != CNT_MAX) begin
                    dur_q[i] <= dur_q[i] + CNT_ONE;
                end
            end
            go_q <= go;
            if (go != '0)              allred_q <= '0;
            else if (allred_q != CNT_MAX) allred_q <= allred_q + CNT_ONE;

            if (viol_code != CODE_NONE) begin
                fault <= 1'b1;
                if (!fault || clr_fault) fault_code <= viol_code;
                if (viol_cnt != VC_MAX)  viol_cnt   <= viol_cnt + 8'd1;
            end else if (clr_fault) begin
                fault      <= 1'b0;
                fault_code <= CODE_NONE;
            end
        end
    end

    // Flash-red request mirrors the latched fault flop
    assign flash_req = fault;

endmodule
